// File: rtl/health_bar_engine.sv
// Animated per-fighter health bars: target/displayed health with per-frame drain/refill,
// damage flash, KO detection, and a one-cycle registered pixel colour path.
module health_bar_engine #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned BAR_W        = 144,
  parameter int unsigned BAR_H        = 12,
  parameter int unsigned COLOR_W      = 6,
  parameter int unsigned HW           = $clog2(BAR_W + 1),
  parameter int unsigned BAR_X0       = 16,
  parameter int unsigned BAR_X1       = 480,
  parameter int unsigned BAR_Y        = 8,
  parameter int unsigned DRAIN_STEP   = 2,
  parameter int unsigned REFILL_STEP  = 4,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned FILL_C       = 61,
  parameter int unsigned GHOST_C      = 48,
  parameter int unsigned EMPTY_C      = 0,
  parameter int unsigned BORDER_C     = 61,
  parameter int unsigned FLASH_C      = 63,
  parameter int unsigned TRANSP_C     = 63
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_start,
  input  logic                      round_reset,
  input  logic [NUM_PLAYERS-1:0]    health_load,
  input  logic [NUM_PLAYERS*HW-1:0] health_in,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [COLOR_W-1:0]        pixel_color,
  output logic                      pixel_valid,
  output logic [NUM_PLAYERS-1:0]    ko
);

  localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);

  localparam logic [HW-1:0] BarFull    = HW'(BAR_W);
  localparam logic [HW-1:0] DrainStep  = HW'(DRAIN_STEP);
  localparam logic [HW-1:0] RefillStep = HW'(REFILL_STEP);
  localparam logic [FW-1:0] FlashLoad  = FW'(FLASH_FRAMES);

  localparam logic [10:0] X0     = 11'(BAR_X0);
  localparam logic [10:0] X1     = 11'(BAR_X1);
  localparam logic [10:0] BarW11 = 11'(BAR_W);
  localparam logic [10:0] YTop   = 11'(BAR_Y);
  localparam logic [10:0] YBot   = 11'(BAR_Y + BAR_H - 1);

  localparam logic [COLOR_W-1:0] FillC   = COLOR_W'(FILL_C);
  localparam logic [COLOR_W-1:0] GhostC  = COLOR_W'(GHOST_C);
  localparam logic [COLOR_W-1:0] EmptyC  = COLOR_W'(EMPTY_C);
  localparam logic [COLOR_W-1:0] BorderC = COLOR_W'(BORDER_C);
  localparam logic [COLOR_W-1:0] FlashC  = COLOR_W'(FLASH_C);
  localparam logic [COLOR_W-1:0] TranspC = COLOR_W'(TRANSP_C);

  typedef enum logic [1:0] {StIdle, StDrain, StRefill, StKo} bar_state_e;

  logic [HW-1:0] target_q    [NUM_PLAYERS];
  logic [HW-1:0] target_d    [NUM_PLAYERS];
  logic [HW-1:0] displayed_q [NUM_PLAYERS];
  logic [HW-1:0] displayed_d [NUM_PLAYERS];
  logic [FW-1:0] flash_q     [NUM_PLAYERS];
  logic [FW-1:0] flash_d     [NUM_PLAYERS];
  logic [HW-1:0] load_val    [NUM_PLAYERS];
  bar_state_e    state_q     [NUM_PLAYERS];
  bar_state_e    state_d     [NUM_PLAYERS];

  logic [COLOR_W-1:0] color_d, color_q;
  logic               valid_d, valid_q;
  logic [10:0]        x, y, x_lo, x_hi, col;
  logic               in_rows, border_row;

  // Clamp incoming health to the bar length before it reaches the target register.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      load_val[p] = health_in[p*HW +: HW];
      if (load_val[p] > BarFull) begin
        load_val[p] = BarFull;
      end
    end
  end

  // Health update; the frame step always uses the target held before this cycle's load.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      target_d[p]    = target_q[p];
      displayed_d[p] = displayed_q[p];
      flash_d[p]     = flash_q[p];
      if (round_reset) begin
        target_d[p]    = BarFull;
        displayed_d[p] = BarFull;
        flash_d[p]     = '0;
      end else begin
        if (frame_start) begin
          if (displayed_q[p] > target_q[p]) begin
            if (displayed_q[p] - target_q[p] > DrainStep) begin
              displayed_d[p] = displayed_q[p] - DrainStep;
            end else begin
              displayed_d[p] = target_q[p];
            end
          end else if (displayed_q[p] < target_q[p]) begin
            if (target_q[p] - displayed_q[p] > RefillStep) begin
              displayed_d[p] = displayed_q[p] + RefillStep;
            end else begin
              displayed_d[p] = target_q[p];
            end
          end
          if (flash_q[p] != '0) begin
            flash_d[p] = flash_q[p] - 1'b1;
          end
        end
        if (health_load[p]) begin
          target_d[p] = load_val[p];
          if (load_val[p] < target_q[p]) begin
            flash_d[p] = FlashLoad;
          end
        end
      end
    end
  end

  // Bar state tracks the register values that will hold after this edge.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      state_d[p] = state_q[p];
      if (displayed_d[p] > target_d[p]) begin
        state_d[p] = StDrain;
      end else if (displayed_d[p] < target_d[p]) begin
        state_d[p] = StRefill;
      end else if (target_d[p] == '0) begin
        state_d[p] = StKo;
      end else begin
        state_d[p] = StIdle;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        target_q[p]    <= BarFull;
        displayed_q[p] <= BarFull;
        flash_q[p]     <= '0;
        state_q[p]     <= StIdle;
      end
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        target_q[p]    <= target_d[p];
        displayed_q[p] <= displayed_d[p];
        flash_q[p]     <= flash_d[p];
        state_q[p]     <= state_d[p];
      end
    end
  end

  always_comb begin
    ko = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      ko[p] = (state_q[p] == StKo);
    end
  end

  // Pixel colour; iterating from the highest player down lets the lowest index win overlaps.
  always_comb begin
    color_d    = TranspC;
    valid_d    = 1'b0;
    x          = {1'b0, DrawX};
    y          = {1'b0, DrawY};
    x_lo       = '0;
    x_hi       = '0;
    col        = '0;
    in_rows    = (y >= YTop) && (y <= YBot);
    border_row = (y == YTop) || (y == YBot);
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      x_lo = (p == 0) ? X0 : X1;
      x_hi = x_lo + BarW11 - 11'd1;
      col  = (p == 0) ? (x - x_lo) : (x_hi - x);
      if (in_rows && (x >= x_lo) && (x <= x_hi)) begin
        valid_d = 1'b1;
        if (border_row || (x == x_lo) || (x == x_hi)) begin
          color_d = BorderC;
        end else if (col < 11'(target_q[p])) begin
          color_d = flash_q[p][0] ? FlashC : FillC;
        end else if (col < 11'(displayed_q[p])) begin
          color_d = GhostC;
        end else begin
          color_d = EmptyC;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      color_q <= TranspC;
      valid_q <= 1'b0;
    end else begin
      color_q <= color_d;
      valid_q <= valid_d;
    end
  end

  assign pixel_color = color_q;
  assign pixel_valid = valid_q;

endmodule

// File: tb/tb_health_bar_engine.sv
// Directed bench for health_bar_engine: bar fill, drain/refill steps, flash, KO, clamp,
// async reset, mirrored bar and out-of-bar pixels.
module tb_health_bar_engine;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        round_reset;
  logic [1:0]  health_load;
  logic [15:0] health_in;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [5:0]  pixel_color;
  logic        pixel_valid;
  logic [1:0]  ko;

  int total = 0;
  int bad   = 0;

  localparam int Y_IN = 13;  // interior row of every bar
  localparam int P0X  = 16;  // p0 pixel x = P0X + c
  localparam int P1E  = 623; // p1 pixel x = P1E - c

  health_bar_engine dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .frame_start (frame_start),
    .round_reset (round_reset),
    .health_load (health_load),
    .health_in   (health_in),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .ko          (ko)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pix(input string tag, input int px, input int py, input logic [5:0] ec,
                     input logic ev);
    draw_x = 10'(px);
    draw_y = 10'(py);
    @(posedge clk);
    #1;
    check(tag, 32'(pixel_color), 32'(ec));
    check({tag, "_v"}, 32'(pixel_valid), 32'(ev));
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
    end
  endtask

  task automatic load(input logic [1:0] m, input logic [7:0] v0, input logic [7:0] v1);
    health_load = m;
    health_in   = {v1, v0};
    @(posedge clk);
    #1;
    health_load = 2'b00;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    round_reset = 1'b0;
    health_load = 2'b00;
    health_in   = '0;
    draw_x      = 10'(P0X + 20);
    draw_y      = 10'(Y_IN);
    repeat (2) @(posedge clk);
    #1;
    check("rst_color", 32'(pixel_color), 32'd63);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_ko", 32'(ko), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. full bar sweep and one-cycle latency
    for (int c = 0; c < 144; c++) begin
      pix($sformatf("sweep_c%0d", c), P0X + c, Y_IN, 6'd61, 1'b1);
    end
    draw_x = 10'd0;
    draw_y = 10'd0;
    #2;
    check("latency_hold", 32'(pixel_color), 32'd61);
    @(posedge clk);
    #1;
    check("latency_next", 32'(pixel_color), 32'd63);
    check("latency_next_v", 32'(pixel_valid), 32'd0);
    check("t1_ko", 32'(ko), 32'd0);

    // 2. damage p0 to 100: ghost region, 2-pixel drain, flash alternation
    load(2'b01, 8'd100, 8'd0);
    pix("t2_flash0", P0X + 50, Y_IN, 6'd61, 1'b1);
    pix("t2_ghost120", P0X + 120, Y_IN, 6'd48, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      frames(1);
      pix($sformatf("t2_flash_f%0d", k), P0X + 50, Y_IN, (k % 2 == 1) ? 6'd63 : 6'd61, 1'b1);
      pix($sformatf("t2_ghost_f%0d", k), P0X + 143 - 2 * k, Y_IN, 6'd48, 1'b1);
      pix($sformatf("t2_empty_f%0d", k), P0X + 144 - 2 * k, Y_IN, 6'd0, 1'b1);
    end
    frames(1);
    pix("t2_flash_done", P0X + 50, Y_IN, 6'd61, 1'b1);

    // 3. p1 to zero -> KO after 72 frames, then refill 0->4->8->10
    load(2'b10, 8'd0, 8'd0);
    frames(71);
    check("t3_ko_71", 32'(ko), 32'd0);
    frames(1);
    check("t3_ko_72", 32'(ko), 32'd2);
    frames(3);
    check("t3_ko_hold", 32'(ko), 32'd2);
    load(2'b10, 8'd0, 8'd10);
    check("t3_ko_clear", 32'(ko), 32'd0);
    frames(1);
    load(2'b10, 8'd0, 8'd1);
    pix("t3_d4_ghost", P1E - 3, Y_IN, 6'd48, 1'b1);
    pix("t3_d4_empty", P1E - 4, Y_IN, 6'd0, 1'b1);
    load(2'b10, 8'd0, 8'd10);
    frames(1);
    load(2'b10, 8'd0, 8'd1);
    pix("t3_d8_ghost", P1E - 7, Y_IN, 6'd48, 1'b1);
    pix("t3_d8_empty", P1E - 8, Y_IN, 6'd0, 1'b1);
    load(2'b10, 8'd0, 8'd10);
    frames(1);
    load(2'b10, 8'd0, 8'd1);
    pix("t3_d10_ghost", P1E - 9, Y_IN, 6'd48, 1'b1);
    pix("t3_d10_empty", P1E - 10, Y_IN, 6'd0, 1'b1);

    // 4. round reset, then load coinciding with frame_start
    round_reset = 1'b1;
    @(posedge clk);
    #1;
    round_reset = 1'b0;
    check("t4_rr_ko", 32'(ko), 32'd0);
    pix("t4_rr_full", P0X + 142, Y_IN, 6'd61, 1'b1);
    pix("t4_rr_p1", P1E - 100, Y_IN, 6'd61, 1'b1);
    health_load = 2'b01;
    health_in   = {8'd0, 8'd50};
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    health_load = 2'b00;
    frame_start = 1'b0;
    pix("t4_nostep", P0X + 142, Y_IN, 6'd48, 1'b1);
    pix("t4_flash8", P0X + 10, Y_IN, 6'd61, 1'b1);
    frames(1);
    pix("t4_step_empty", P0X + 142, Y_IN, 6'd0, 1'b1);
    pix("t4_step_ghost", P0X + 141, Y_IN, 6'd48, 1'b1);
    pix("t4_flash7", P0X + 10, Y_IN, 6'd63, 1'b1);

    // 5. clamp of 200 to 144: a later load of 144 is no damage, so no flash
    load(2'b01, 8'd200, 8'd0);
    frames(7);
    pix("t5_refilled", P0X + 142, Y_IN, 6'd61, 1'b1);
    load(2'b01, 8'd144, 8'd0);
    frames(1);
    pix("t5_clamp_noflash", P0X + 10, Y_IN, 6'd61, 1'b1);

    // async reset mid-drain with p1 in KO
    load(2'b10, 8'd0, 8'd0);
    frames(60);
    load(2'b01, 8'd20, 8'd0);
    frames(12);
    check("t5_pre_ko", 32'(ko), 32'd2);
    pix("t5_pre_ghost", P0X + 100, Y_IN, 6'd48, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_color", 32'(pixel_color), 32'd63);
    check("t5_async_valid", 32'(pixel_valid), 32'd0);
    check("t5_async_ko", 32'(ko), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    pix("t5_post_p0", P0X + 100, Y_IN, 6'd61, 1'b1);
    pix("t5_post_p1", P1E - 3, Y_IN, 6'd61, 1'b1);
    check("t5_post_ko", 32'(ko), 32'd0);

    // 6. mirrored bar settled at 44, borders and out-of-bar pixels
    load(2'b10, 8'd0, 8'd44);
    frames(50);
    pix("t6_fill43", 480 + 143 - 43, Y_IN, 6'd61, 1'b1);
    pix("t6_empty44", 480 + 143 - 44, Y_IN, 6'd0, 1'b1);
    pix("t6_border_col", 480, Y_IN, 6'd61, 1'b1);
    pix("t6_border_top", 500, 8, 6'd61, 1'b1);
    pix("t6_border_bot", 100, 19, 6'd61, 1'b1);
    pix("t6_below", 100, 20, 6'd63, 1'b0);
    pix("t6_between", 300, Y_IN, 6'd63, 1'b0);
    pix("t6_right", 624, Y_IN, 6'd63, 1'b0);
    check("t6_ko", 32'(ko), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
